// File: rtl/conway_matrix_scanner_pkg.sv
// Shared definitions for the Conway matrix scanner: grid size (from `MAX_X/`MAX_Y),
// viewport size, FSM encoding and coordinate helpers.
`ifndef MAX_X
`define MAX_X 16
`endif
`ifndef MAX_Y
`define MAX_Y 16
`endif

package conway_matrix_scanner_pkg;

    localparam int unsigned GRID_X = `MAX_X;
    localparam int unsigned GRID_Y = `MAX_Y;
    localparam int unsigned GRID_N = GRID_X * GRID_Y;
    localparam int unsigned VIEW_W = 8;
    localparam int unsigned VIEW_H = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LATCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_DWELL = 3'd3,
        ST_BLANK = 3'd4
    } scan_state_e;

    // base is always < lim, so one conditional subtract is enough to wrap.
    function automatic logic [8:0] wrap_add(input logic [7:0] base, input logic [8:0] off,
                                            input int unsigned lim);
        logic [8:0] s;
        s = {1'b0, base} + off;
        if (32'(s) >= lim) s = s - 9'(lim);
        return s;
    endfunction

    function automatic logic [7:0] clamp_coord(input logic [7:0] v, input int unsigned lim);
        return (32'(v) < lim) ? v : 8'd0;
    endfunction

endpackage

// File: rtl/conway_matrix_scanner_if.sv
// Bus between the grid source and the matrix scanner; master drives grid/view, slave drives the matrix pins.
// Cursor overlay signals exist only when CURSOR_OVERLAY_EN is defined.
interface conway_matrix_scanner_if;
    import conway_matrix_scanner_pkg::*;

    logic [GRID_N-1:0] state;
    logic              hold;
    logic [7:0]        view_x;
    logic [7:0]        view_y;
`ifdef CURSOR_OVERLAY_EN
    logic [7:0]        cursor_x;
    logic [7:0]        cursor_y;
    logic [63:0]       pattern_mat;
`endif
    logic [7:0]        row_sel;
    logic [7:0]        col_data;
    logic              frame_done;
    logic              busy;
    scan_state_e       fsm_state;

`ifdef CURSOR_OVERLAY_EN
    modport master (output state, hold, view_x, view_y, cursor_x, cursor_y, pattern_mat,
                    input  row_sel, col_data, frame_done, busy, fsm_state);
    modport slave  (input  state, hold, view_x, view_y, cursor_x, cursor_y, pattern_mat,
                    output row_sel, col_data, frame_done, busy, fsm_state);
`else
    modport master (output state, hold, view_x, view_y,
                    input  row_sel, col_data, frame_done, busy, fsm_state);
    modport slave  (input  state, hold, view_x, view_y,
                    output row_sel, col_data, frame_done, busy, fsm_state);
`endif

endinterface

// File: rtl/conway_row_fetch.sv
// Combinational extraction of one 8-cell viewport row with toroidal wrap.
// With CURSOR_OVERLAY_EN defined, the blinking cursor pattern is XORed into the row.
module conway_row_fetch
    import conway_matrix_scanner_pkg::*;
(
    input  logic [GRID_N-1:0] snap_i,
    input  logic [7:0]        vx_i,
    input  logic [7:0]        vy_i,
    input  logic [2:0]        row_i,
`ifdef CURSOR_OVERLAY_EN
    input  logic              blink_i,
    input  logic [7:0]        cx_i,
    input  logic [7:0]        cy_i,
    input  logic [63:0]       pat_i,
`endif
    output logic [VIEW_W-1:0] bits_o
);

    localparam int IDX_W = $clog2(GRID_N);

    logic [8:0] gx;
    logic [8:0] gy;
`ifdef CURSOR_OVERLAY_EN
    logic [8:0] dx;
    logic [8:0] dy;
`endif

    always_comb begin
        bits_o = '0;
        gx     = '0;
        gy     = wrap_add(vy_i, {6'd0, row_i}, GRID_Y);
`ifdef CURSOR_OVERLAY_EN
        dx = '0;
        // Offset of this grid row from the cursor origin, modulo the grid height.
        dy = (gy >= {1'b0, cy_i}) ? gy - {1'b0, cy_i} : gy + 9'(GRID_Y) - {1'b0, cy_i};
`endif
        for (int c = 0; c < VIEW_W; c++) begin
            gx = wrap_add(vx_i, 9'(c), GRID_X);
            bits_o[c] = snap_i[IDX_W'(32'(gy) * GRID_X + 32'(gx))];
`ifdef CURSOR_OVERLAY_EN
            dx = (gx >= {1'b0, cx_i}) ? gx - {1'b0, cx_i} : gx + 9'(GRID_X) - {1'b0, cx_i};
            if (blink_i && dx < 9'd8 && dy < 9'd8)
                bits_o[c] = bits_o[c] ^ pat_i[{dy[2:0], dx[2:0]}];
`endif
        end
    end

endmodule

// File: rtl/conway_matrix_scanner.sv
// Row-multiplexed 8x8 LED matrix driver over a once-per-frame snapshot of the Conway grid.
// Optional blinking cursor overlay is enabled by defining CURSOR_OVERLAY_EN.
module conway_matrix_scanner
    import conway_matrix_scanner_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 1000,
    parameter int unsigned BLANK_CYCLES = 2
) (
    input logic                    clk,
    input logic                    rst,
    conway_matrix_scanner_if.slave bus
);

    scan_state_e       state_q;
    logic [GRID_N-1:0] snap_q;
    logic [7:0]        vx_q;
    logic [7:0]        vy_q;
    logic [2:0]        row_q;
    logic [31:0]       cnt_q;
    logic [7:0]        row_sel_q;
    logic [7:0]        col_data_q;
    logic              frame_done_q;
    logic              busy_q;
    logic [7:0]        fetch_row;
`ifdef CURSOR_OVERLAY_EN
    logic [7:0]        cx_q;
    logic [7:0]        cy_q;
    logic [63:0]       pat_q;
    logic              blink_q;
`endif

    conway_row_fetch u_fetch (
        .snap_i  (snap_q),
        .vx_i    (vx_q),
        .vy_i    (vy_q),
        .row_i   (row_q),
`ifdef CURSOR_OVERLAY_EN
        .blink_i (blink_q),
        .cx_i    (cx_q),
        .cy_i    (cy_q),
        .pat_i   (pat_q),
`endif
        .bits_o  (fetch_row)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            snap_q       <= '0;
            vx_q         <= '0;
            vy_q         <= '0;
            row_q        <= '0;
            cnt_q        <= '0;
            row_sel_q    <= '0;
            col_data_q   <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
`ifdef CURSOR_OVERLAY_EN
            cx_q         <= '0;
            cy_q         <= '0;
            pat_q        <= '0;
            blink_q      <= 1'b0;
`endif
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    busy_q  <= 1'b1;
                    state_q <= ST_LATCH;
                end
                ST_LATCH: begin
                    // Only sampling point for the inputs, which keeps each frame tear-free.
                    if (!bus.hold) snap_q <= bus.state;
                    vx_q    <= clamp_coord(bus.view_x, GRID_X);
                    vy_q    <= clamp_coord(bus.view_y, GRID_Y);
`ifdef CURSOR_OVERLAY_EN
                    cx_q    <= clamp_coord(bus.cursor_x, GRID_X);
                    cy_q    <= clamp_coord(bus.cursor_y, GRID_Y);
                    pat_q   <= bus.pattern_mat;
`endif
                    row_q   <= '0;
                    state_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    row_sel_q  <= 8'd1 << row_q;
                    col_data_q <= fetch_row;
                    cnt_q      <= '0;
                    state_q    <= ST_DWELL;
                end
                ST_DWELL: begin
                    if (cnt_q == DWELL_CYCLES - 1) begin
                        cnt_q      <= '0;
                        row_sel_q  <= '0;
                        col_data_q <= '0;
                        state_q    <= ST_BLANK;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                ST_BLANK: begin
                    if (cnt_q == BLANK_CYCLES - 1) begin
                        cnt_q <= '0;
                        if (row_q == 3'd7) begin
                            frame_done_q <= 1'b1;
`ifdef CURSOR_OVERLAY_EN
                            blink_q      <= ~blink_q;
`endif
                            state_q      <= ST_LATCH;
                        end else begin
                            row_q   <= row_q + 3'd1;
                            state_q <= ST_LOAD;
                        end
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.row_sel    = row_sel_q;
    assign bus.col_data   = col_data_q;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = busy_q;
    assign bus.fsm_state  = state_q;

endmodule

// File: tb/tb_conway_matrix_scanner.sv
// Directed bench for conway_matrix_scanner on a 16x16 grid, DWELL_CYCLES=4, BLANK_CYCLES=1.
// Define CURSOR_OVERLAY_EN together with the RTL to also exercise the blinking cursor.
module tb_conway_matrix_scanner;
  import conway_matrix_scanner_pkg::*;

  localparam int DWELL = 4;
  localparam int BLANK = 1;
  localparam int PER_ROW = 1 + DWELL + BLANK;
  localparam int FRAME = 8 * PER_ROW + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  conway_matrix_scanner_if bus ();

  conway_matrix_scanner #(
    .DWELL_CYCLES (DWELL),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  logic [GRID_N-1:0] nxt_state;
  logic              nxt_hold;
  logic [7:0]        nxt_vx;
  logic [7:0]        nxt_vy;

  logic [GRID_N-1:0] s1;
  logic [GRID_N-1:0] s2;
  logic [GRID_N-1:0] s3;

  // Hand-computed 8x8 viewport images, byte r = row r, bit c = column c.
  localparam logic [63:0] IMG1 = 64'h0000_0000_0400_0000;
  localparam logic [63:0] IMG2 = 64'h0000_0000_0020_0000;
  localparam logic [63:0] IMG1_V15 = 64'h0000_0008_0000_0000;
  localparam logic [63:0] IMG3 = 64'h0000_0400_0000_0201;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_next();
    bus.state = nxt_state;
    bus.hold = nxt_hold;
    bus.view_x = nxt_vx;
    bus.view_y = nxt_vy;
  endtask

  task automatic set_next(input logic [GRID_N-1:0] st, input logic h,
                          input logic [7:0] vx, input logic [7:0] vy);
    nxt_state = st;
    nxt_hold = h;
    nxt_vx = vx;
    nxt_vy = vy;
  endtask

  // Entered while LATCH is visible; walks one full frame, applying the pending inputs mid-frame.
  task automatic check_frame(input string name, input logic [63:0] img);
    logic [7:0] exp_sel;
    logic [7:0] exp_col;
    int r;
    int k;
    check_eq({name, "_latch"}, 64'(bus.fsm_state), 64'(ST_LATCH));
    check_eq({name, "_busy"}, 64'(bus.busy), 64'd1);
    for (int t = 1; t <= FRAME; t++) begin
      tick();
      if (t == 20) apply_next();
      exp_sel = 8'h00;
      exp_col = 8'h00;
      if (t < FRAME) begin
        r = (t - 1) / PER_ROW;
        k = (t - 1) % PER_ROW;
        if (k >= 1 && k <= DWELL) begin
          exp_sel = 8'h01 << r;
          exp_col = img[r*8 +: 8];
        end
      end
      check_eq($sformatf("%s_t%0d_row_sel", name, t), 64'(bus.row_sel), 64'(exp_sel));
      check_eq($sformatf("%s_t%0d_col_data", name, t), 64'(bus.col_data), 64'(exp_col));
      check_eq($sformatf("%s_t%0d_frame_done", name, t), 64'(bus.frame_done),
               (t == FRAME) ? 64'd1 : 64'd0);
    end
  endtask

  initial begin
    s1 = '0;
    s1[3*16+2] = 1'b1;
    s2 = '0;
    s2[0*16+1] = 1'b1;
    s3 = '0;
    s3[0] = 1'b1;
    s3[7*16+7] = 1'b1;
    s3[15*16+15] = 1'b1;
    s3[4*16+1] = 1'b1;

    bus.state = s1;
    bus.hold = 1'b0;
    bus.view_x = 8'd0;
    bus.view_y = 8'd0;
`ifdef CURSOR_OVERLAY_EN
    bus.cursor_x = 8'd0;
    bus.cursor_y = 8'd0;
    bus.pattern_mat = 64'd0;
`endif

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    check_eq("rst_row_sel", 64'(bus.row_sel), 64'd0);
    check_eq("rst_col_data", 64'(bus.col_data), 64'd0);
    check_eq("rst_frame_done", 64'(bus.frame_done), 64'd0);
    check_eq("rst_busy", 64'(bus.busy), 64'd0);
    check_eq("rst_fsm", 64'(bus.fsm_state), 64'(ST_IDLE));

    rst = 1'b0;
    tick();
    check_eq("release_busy", 64'(bus.busy), 64'd1);

    // Single cell, then mid-frame switch to a wrapped view (tear-free)
    set_next(s2, 1'b0, 8'd12, 8'd14);
    check_frame("single", IMG1);
    set_next(s1, 1'b0, 8'd20, 8'd200);
    check_frame("wrap", IMG2);
    // Out-of-range view clamps to the origin; then hold keeps s1 under a new view
    set_next(s3, 1'b1, 8'd15, 8'd15);
    check_frame("oor_view", IMG1);
    set_next(s3, 1'b0, 8'd15, 8'd15);
    check_frame("hold", IMG1_V15);
    check_frame("multi", IMG3);

    // Reset in the middle of row 5's dwell
    for (int t = 1; t <= 2 + 5 * PER_ROW; t++) tick();
    check_eq("pre_rst_row_sel", 64'(bus.row_sel), 64'h20);
    check_eq("pre_rst_col_data", 64'(bus.col_data), 64'h04);
    rst = 1'b1;
    bus.state = s1;
    bus.hold = 1'b1;
    bus.view_x = 8'd0;
    bus.view_y = 8'd0;
    tick();
    check_eq("mid_rst_row_sel", 64'(bus.row_sel), 64'd0);
    check_eq("mid_rst_col_data", 64'(bus.col_data), 64'd0);
    check_eq("mid_rst_busy", 64'(bus.busy), 64'd0);
    check_eq("mid_rst_fsm", 64'(bus.fsm_state), 64'(ST_IDLE));
    rst = 1'b0;
    tick();
    set_next(s1, 1'b0, 8'd0, 8'd0);
    check_frame("post_rst_empty", 64'd0);
    check_frame("post_rst_relatch", IMG1);

`ifdef CURSOR_OVERLAY_EN
    rst = 1'b1;
    bus.state = '0;
    bus.hold = 1'b0;
    bus.view_x = 8'd0;
    bus.view_y = 8'd0;
    bus.cursor_x = 8'd0;
    bus.cursor_y = 8'd0;
    bus.pattern_mat = 64'h1;
    tick();
    rst = 1'b0;
    tick();
    set_next('0, 1'b0, 8'd0, 8'd0);
    check_frame("cur_f1", 64'd0);
    check_frame("cur_f2", 64'h1);
    set_next(s3 & 256'h1, 1'b0, 8'd0, 8'd0);
    check_frame("cur_f3", 64'd0);
    check_frame("cur_f4", 64'd0);
    check_frame("cur_f5", 64'h1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conway_matrix_scanner.md
Name: conway_matrix_scanner

Overview:
- Display-side consumer of the Conway engine's flattened `MAX_X*`MAX_Y generation vector.
- Snapshots the grid once per frame and extracts an 8x8 viewport at (view_x, view_y) with toroidal wrap.
- Drives an 8x8 LED dot matrix by row multiplexing: one-hot row select, 8-bit column data, dwell and blanking timing.
- Sits between conway_fsm's state output and the board's matrix pins.

Parameters:
- DWELL_CYCLES, 1000: clocks each row is lit, minimum 1.
- BLANK_CYCLES, 2: clocks all rows dark between rows (anti-ghosting), minimum 1.
- Grid size comes from the `MAX_X / `MAX_Y macros, both ≥8 and ≤256; it is not a parameter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- state  in  `MAX_X*`MAX_Y  live grid; bit index y*`MAX_X+x.
- hold  in  1  1 = keep the previous snapshot at the frame boundary.
- view_x  in  8  viewport left column.
- view_y  in  8  viewport top row.
- row_sel  out  8  one-hot lit row; bit r = viewport row r; all-zero = dark.
- col_data  out  8  bit c = cell (view_x+c, view_y+r) of the lit row.
- frame_done  out  1  one-cycle pulse after row 7's blank completes.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset, synchronous, active-high. rst=1 at any clock edge, including mid-frame, forces:
  - FSM to IDLE; row, dwell and blank counters to 0.
  - row_sel=0, col_data=0, frame_done=0, busy=0.
  - snapshot to all zeros; latched view_x/view_y to 0.
- FSM states: IDLE, LATCH, LOAD, DWELL, BLANK.
- IDLE: entered only from reset. Moves to LATCH on the next clock after rst deasserts.
- LATCH, 1 cycle:
  - If hold=0, snapshot<=state; if hold=1, the snapshot is unchanged.
  - view_x/view_y latched. A value ≥`MAX_X (resp. ≥`MAX_Y) is latched as 0.
  - Row counter r<=0. Next state LOAD.
- LOAD, 1 cycle: row_buf<=fetch(snapshot, vx, vy, r). row_sel stays 0. Next state DWELL.
- DWELL, DWELL_CYCLES cycles: row_sel=1<<r and col_data=row_buf, both registered outputs. Then BLANK.
- BLANK, BLANK_CYCLES cycles: row_sel=0, col_data=0. Then:
  - if r<7: r<=r+1, go to LOAD;
  - if r==7: frame_done=1 for exactly one cycle (the transition cycle), go to LATCH.
- Frame length is 8*(1+DWELL_CYCLES+BLANK_CYCLES)+1 clocks.
- Fetch wrap rules:
  - column index = vx+c; subtract `MAX_X if ≥`MAX_X.
  - row index = vy+r; subtract `MAX_Y if ≥`MAX_Y.
  - Arithmetic is 9-bit, so no overflow at 255+7.
- Tear-free guarantee: state, hold, view_x and view_y are sampled only in LATCH. Changes mid-frame take effect at the next frame.
- Simultaneous events: a state change in the same cycle as LATCH is captured, since it samples the current input value.
- Safety invariants:
  - row_sel is never more than one-hot.
  - row_sel is zero for at least BLANK_CYCLES between two different rows, and also across the frame boundary (LATCH and LOAD are dark).

Optional Feature:
- Macro: CURSOR_OVERLAY_EN.
- When defined, adds these inputs:
  - cursor_x[7:0], cursor_y[7:0]: overlay origin.
  - pattern_mat[63:0]: bit dy*8+dx = overlay cell.
- Overlay behaviour:
  - Inputs are latched in LATCH alongside the view coordinates.
  - A 1-bit blink flag toggles on each frame_done. Reset value 0.
  - When blink=1, each viewport cell whose wrapped grid coordinate equals (cursor_x+dx, cursor_y+dy) mod grid for a set pattern_mat bit is XORed into row_buf during LOAD.
  - Cursor wrap uses the same rules as the fetch.
- When undefined: the ports do not exist, there is no blink flag, and col_data is the raw snapshot.

Decomposition:
- Shared package/include holds:
  - the `MAX_X/`MAX_Y macros;
  - VIEW_W=8, VIEW_H=8;
  - the FSM state localparams (IDLE=0, LATCH=1, LOAD=2, DWELL=3, BLANK=4).
- One sub-module, conway_row_fetch: combinational extraction of 8 wrapped bits given snapshot, vx, vy, r. The overlay XOR is added inside it under the macro.
- Counters and FSM stay in the top module.

Test Plan:
All scenarios use MAX_X=MAX_Y=16, DWELL_CYCLES=4, BLANK_CYCLES=1, so frame length = 49 clocks.

1. Reset, then release with state having only bit (x=2, y=3) set and view=(0,0):
   - busy rises 1 clock after release.
   - row_sel=8'h08 with col_data=8'h04 for exactly 4 clocks.
   - All other rows show col_data=0.
   - frame_done pulses 49 clocks after LATCH.
2. Wrap: view=(12,14), cell (1,0) set -> the lit row is r=2 (row_sel=8'h04), with col_data=8'h20 (c=5).
3. Out-of-range view: view_x=20, view_y=200 -> latched as (0,0); output identical to scenario 1.
4. Tear-free and hold:
   - Change state mid-frame -> the current frame's output is unchanged and the new data appears next frame.
   - With hold=1 at LATCH -> the old image persists a further frame.
5. rst pulsed during DWELL of row 5 -> next clock row_sel=0, col_data=0, busy=0; scanning restarts from row 0 with an empty snapshot until the next LATCH.
6. (CURSOR_OVERLAY_EN) pattern_mat=64'h1 at cursor (0,0) over an empty grid, view=(0,0):
   - Frame 1: bit0 of row 0 is 0.
   - Frame 2: bit0 is 1.
   - Frame 3: bit0 is 0.
   - Cell (0,0) set in state -> inverted phases.
